// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle datapath controller.
package mc_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 6;

    localparam logic [STATE_W-1:0] S_FETCH     = 4'd0;
    localparam logic [STATE_W-1:0] S_DECODE    = 4'd1;
    localparam logic [STATE_W-1:0] S_MEM_ADDR  = 4'd2;
    localparam logic [STATE_W-1:0] S_MEM_READ  = 4'd3;
    localparam logic [STATE_W-1:0] S_MEM_WB    = 4'd4;
    localparam logic [STATE_W-1:0] S_MEM_WRITE = 4'd5;
    localparam logic [STATE_W-1:0] S_R_EXEC    = 4'd6;
    localparam logic [STATE_W-1:0] S_R_WB      = 4'd7;
    localparam logic [STATE_W-1:0] S_BRANCH    = 4'd8;
    localparam logic [STATE_W-1:0] S_JUMP      = 4'd9;
    localparam logic [STATE_W-1:0] S_ADDI_EXEC = 4'd10;
    localparam logic [STATE_W-1:0] S_ADDI_WB   = 4'd11;
    localparam logic [STATE_W-1:0] S_HALT      = 4'd12;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Full control word driven toward the datapath.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       i_or_d;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       pc_en;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/mc_out_decode.sv
// Moore output decode: state -> control word, with FETCH gated by mem_ready
// and the branch PC load gated by the ALU zero flag.
module mc_out_decode
    import mc_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       mem_ready_i,
    input  logic       zero_i,
    output ctrl_t      ctrl_o
);

    logic pc_write;
    logic pc_write_cond;

    // Per-state control values; everything not named for a state stays 0.
    always_comb begin
        ctrl_o        = '0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                pc_write         = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_SHIMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.pc_source = PCSRC_ALUOUT;
                pc_write_cond    = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_source = PCSRC_JUMP;
                pc_write         = 1'b1;
            end
            S_ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_HALT: begin
                ctrl_o.halted = 1'b1;
            end
            default: ;
        endcase
        ctrl_o.pc_en = pc_write | (pc_write_cond & zero_i);
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: state register, next-state logic and
// retired-instruction counter; output decode lives in mc_out_decode.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             pc_en,
    output logic             halted,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [CNT_W-1:0]   retired_q;
    logic [CNT_W-1:0]   retired_d;
    logic               retire_c;
    ctrl_t              ctrl_raw;
    ctrl_t              ctrl_gated;

    // Next state and end-of-instruction detection.
    always_comb begin
        state_d  = state_q;
        retire_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR: begin
                state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
            S_MEM_WRITE: begin
                if (mem_ready) begin
                    state_d  = S_FETCH;
                    retire_c = 1'b1;
                end
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
        retired_d = retire_c ? retired_q + CNT_W'(1) : retired_q;
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    mc_out_decode u_out_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .zero_i      (zero),
        .ctrl_o      (ctrl_raw)
    );

    // Reset forces every control output quiet, independent of state.
    assign ctrl_gated = rst ? ctrl_raw : '0;

    assign mem_read   = ctrl_gated.mem_read;
    assign mem_write  = ctrl_gated.mem_write;
    assign ir_write   = ctrl_gated.ir_write;
    assign i_or_d     = ctrl_gated.i_or_d;
    assign reg_write  = ctrl_gated.reg_write;
    assign reg_dst    = ctrl_gated.reg_dst;
    assign mem_to_reg = ctrl_gated.mem_to_reg;
    assign alu_src_a  = ctrl_gated.alu_src_a;
    assign alu_src_b  = ctrl_gated.alu_src_b;
    assign alu_op     = ctrl_gated.alu_op;
    assign pc_source  = ctrl_gated.pc_source;
    assign pc_en      = ctrl_gated.pc_en;
    assign halted     = ctrl_gated.halted;
    assign state      = state_q;
    assign retired    = retired_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port opcode  in  6  IR[31:26]; stable from DECODE until the instruction ends.
REQ-005 SHALL have port zero  in  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  in  1  shared memory has completed the current read or write this cycle.
REQ-007 SHALL have port mem_read, mem_write, ir_write, i_or_d  out  1 each  memory and IR controls; i_or_d=1 selects the ALUOut address.
REQ-008 SHALL have port reg_write, reg_dst, mem_to_reg, alu_src_a  out  1 each  register-file and ALU-A controls.
REQ-009 SHALL have port alu_src_b  out  2  ALU-B select: 00 reg B, 01 const 4, 10 sign-extended immediate, 11 shifted immediate.
REQ-010 SHALL have port alu_op  out  2  to ALUControl: 00 add, 01 sub, 10 funct.
REQ-011 SHALL have port pc_source  out  2  PC-mux select: 00 ALU, 01 ALUOut, 10 jump target.
REQ-012 SHALL have port pc_en  out  1  PC load, equal to pc_write | (pc_write_cond & zero).
REQ-013 SHALL have port halted  out  1  high in HALT.
REQ-014 SHALL have port state  out  4  current state, for debug.
REQ-015 SHALL have port retired  out  CNT_W  count of completed instructions.

Function
REQ-016 SHALL be a Moore FSM; outputs decode from state, except where a signal is gated by mem_ready or zero.
REQ-017 SHALL use these states: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, HALT=12.
REQ-018 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; go to DECODE when mem_ready=1, else hold.
REQ-019 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; branch on opcode.
  - 000000 -> R_EXEC
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EXEC
  - any other opcode -> HALT
REQ-020 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; go to MEM_READ for lw, MEM_WRITE for sw.
REQ-021 MEM_READ: mem_read=1, i_or_d=1; go to MEM_WB on mem_ready, else hold.
REQ-022 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
REQ-023 MEM_WRITE: mem_write=1, i_or_d=1; go to FETCH on mem_ready, else hold.
REQ-024 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; then R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
REQ-025 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; then FETCH.
REQ-026 JUMP: pc_write=1, pc_source=10; then FETCH.
REQ-027 ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00; then ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
REQ-028 HALT: every control output SHALL be 0 and halted=1; HALT SHALL be left only by reset.
REQ-029 Any output not listed for a state SHALL be 0.
REQ-030 Memory accesses SHALL stall indefinitely while mem_ready=0, with outputs held constant; mem_ready outside FETCH, MEM_READ and MEM_WRITE SHALL be ignored.
REQ-031 retired SHALL increment by 1 on the final cycle of each instruction, wrapping modulo 2^CNT_W.
  - Final cycles: MEM_WB; MEM_WRITE when mem_ready=1; R_WB; BRANCH; JUMP; ADDI_WB.
  - No increment on entry to HALT.
REQ-032 Latency SHALL be, with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-033 When rst=0 at a rising edge, state SHALL become FETCH and retired SHALL become 0, including mid-instruction and mid-stall.
REQ-034 While rst=0, all control outputs, pc_en and halted SHALL be forced to 0.

Structure
REQ-035 A shared package mc_pkg SHALL hold the state encodings, opcode constants, and the alu_src_b, alu_op and pc_source codes.
REQ-036 A sub-module mc_out_decode (state, mem_ready, zero -> control word, combinational) SHALL implement the output decode; the state register and counter SHALL stay in the top module.

Verification
REQ-037 R-type (opcode 000000), mem_ready=1 on every FETCH -> states 0,1,6,7,0; reg_write=1 and reg_dst=1 in state 7; retired goes 0->1.
REQ-038 lw (100011), mem_ready=0 for 3 cycles in MEM_READ -> state 3 held 4 cycles with outputs stable; total 8 cycles; mem_to_reg=1 in state 4.
REQ-039 beq (000100): with zero=1 -> pc_en=1, pc_source=01 in state 8; with zero=0 -> pc_en=0; retired increments in both cases.
REQ-040 Opcode 111111 -> HALT after DECODE; halted=1; retired unchanged after 10 further cycles; rst=0 for 1 cycle -> state=0, retired=0.
REQ-041 rst=0 asserted during MEM_WRITE stall -> next state=0, mem_write=0 while rst=0, no increment.
REQ-042 With CNT_W=4, 16 j instructions (000010) -> retired wraps from 15 to 0.
